// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results and a one-cycle done.
// Optional `DIV_SIGNED_EN: two's-complement operands, with an extra FIX cycle that applies the result signs.
module restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;
`ifdef DIV_SIGNED_EN
  logic [WIDTH-1:0] r_a;
  logic             r_sa;
  logic             r_sb;
`endif

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  always_comb begin
`ifdef DIV_SIGNED_EN
    w_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    w_b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
    w_a_mag = a;
    w_b_mag = b;
`endif
  end

  // One restoring step: shift {P,Q} left, trial-subtract D, keep P if the trial went negative.
  always_comb begin
    w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    w_t       = w_p_shift - {1'b0, r_d};
    w_p_next  = w_t[WIDTH] ? w_p_shift : w_t;
    w_q_next  = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
`ifdef DIV_SIGNED_EN
      S_RUN:  if (w_last) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_IDLE;
`else
      S_RUN:  if (w_last) w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = r_done;
    quotient    = r_quotient;
    remainder   = r_remainder;
    div_by_zero = r_dz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_a         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p   <= '0;
            r_q   <= w_a_mag;
            r_d   <= w_b_mag;
            r_cnt <= '0;
`ifdef DIV_SIGNED_EN
            r_a   <= a;
            r_sa  <= a[WIDTH-1];
            r_sb  <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifndef DIV_SIGNED_EN
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_p_next[WIDTH-1:0];
            r_dz        <= (r_d == '0);
            r_done      <= 1'b1;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        // Divide-by-zero bypasses the sign fix so the result stays all-ones r a.
        S_FIX: begin
          r_quotient  <= ((r_d != '0) && (r_sa != r_sb)) ? (~r_q + 1'b1) : r_q;
          r_remainder <= (r_d == '0) ? r_a :
                         (r_sa ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0]);
          r_dz        <= (r_d == '0);
          r_done      <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
